// File: rtl/alu_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg
//   Definitions shared by the ALU arithmetic blocks (Booth multiplier and the
//   non-restoring divider that sits beside it on the same operand/result buses).
//
//   ALU_WIDTH     default operand width of the ALU datapath
//   mult_state_t  control states of the sequential multiplier
// -----------------------------------------------------------------------------
package alu_pkg;

  localparam int ALU_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,  // waiting for operands, in_ready high
    CALC = 2'd1,  // one Booth add/sub + shift per clock
    DONE = 2'd2   // product presented, waiting for out_ready
  } mult_state_t;

  // True when a 2*w-bit signed value cannot be represented in w signed bits,
  // i.e. the bits from the top down to bit w-1 are not all copies of the sign.
  // The slice is passed in already extracted so the function is width-agnostic.
  function automatic logic sign_bits_differ(input logic [63:0] top_bits,
                                            input int unsigned n_bits);
    logic all_ones;
    logic all_zeros;
    all_ones  = 1'b1;
    all_zeros = 1'b1;
    for (int unsigned i = 0; i < 64; i++) begin
      if (i < n_bits) begin
        all_ones  = all_ones  & top_bits[i];
        all_zeros = all_zeros & ~top_bits[i];
      end
    end
    return !(all_ones || all_zeros);
  endfunction

endpackage : alu_pkg

// File: rtl/booth_step.sv
// -----------------------------------------------------------------------------
// booth_step
//   One combinational radix-2 Booth iteration: conditional add/subtract of the
//   multiplicand into the accumulator, then an arithmetic right shift of the
//   concatenated {A, Q, Q_-1} register by one position.
//
//   Ports
//     a_i     [WIDTH:0]    accumulator A (one guard bit so -M never overflows)
//     q_i     [WIDTH-1:0]  multiplier / low product bits Q
//     q_m1_i               Q_-1, the bit shifted out of Q on the previous step
//     m_i     [WIDTH:0]    sign-extended multiplicand M
//     a_o, q_o, q_m1_o     the same three fields after this step
// -----------------------------------------------------------------------------
module booth_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH:0]   a_i,
  input  logic [WIDTH-1:0] q_i,
  input  logic             q_m1_i,
  input  logic [WIDTH:0]   m_i,
  output logic [WIDTH:0]   a_o,
  output logic [WIDTH-1:0] q_o,
  output logic             q_m1_o
);

  logic [WIDTH:0] sum;

  // NOTE: every signal written in always_comb gets a default first so that no
  // path through the case leaves it unassigned, which would infer a latch.
  always_comb begin
    sum = a_i;
    unique case ({q_i[0], q_m1_i})
      2'b01:   sum = a_i + m_i;           // end of a run of ones: add M
      2'b10:   sum = a_i + (~m_i) + 1'b1; // start of a run of ones: subtract M
      default: sum = a_i;                 // inside a run: no change
    endcase
  end

  // Arithmetic shift right of {sum, q_i, q_m1_i}; the accumulator sign is
  // replicated into the vacated MSB.
  assign a_o    = {sum[WIDTH], sum[WIDTH:1]};
  assign q_o    = {sum[0], q_i[WIDTH-1:1]};
  assign q_m1_o = q_i[0];

endmodule : booth_step

// File: rtl/booth_mult_seq.sv
// -----------------------------------------------------------------------------
// booth_mult_seq
//   Sequential signed radix-2 Booth multiplier. Operands are accepted with a
//   valid/ready handshake, WIDTH Booth steps run one per clock, and the 2*WIDTH
//   product is held registered until the consumer accepts it.
//
//   Optional feature macro: BOOTH_OVF_EN
//     defined   -> ovf output present; set when the product does not fit in
//                  WIDTH signed bits, registered together with product.
//     undefined -> no ovf port and no overflow logic.
//
//   Ports
//     clk           rising-edge clock
//     rst_n         asynchronous active-low reset
//     in_valid      operands valid
//     in_ready      idle, operands can be accepted
//     multiplicand  signed M, sampled on accept
//     multiplier    signed Q, sampled on accept
//     out_valid     product valid, held until accepted
//     out_ready     consumer accepts product
//     ovf           (BOOTH_OVF_EN only) product overflows WIDTH signed bits
//     product       signed M*Q, 2*WIDTH bits
// -----------------------------------------------------------------------------
module booth_mult_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     multiplicand,
  input  logic [WIDTH-1:0]     multiplier,
  output logic                 out_valid,
  input  logic                 out_ready,
`ifdef BOOTH_OVF_EN
  output logic                 ovf,
`endif
  output logic [2*WIDTH-1:0]   product
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  mult_state_t          state_q, state_d;
  logic [CNT_W-1:0]     count_q, count_d;
  logic [WIDTH:0]       a_q, a_d;
  logic [WIDTH-1:0]     q_q, q_d;
  logic                 q_m1_q, q_m1_d;
  logic [WIDTH:0]       m_q, m_d;
  logic [2*WIDTH-1:0]   product_q, product_d;
`ifdef BOOTH_OVF_EN
  logic                 ovf_q, ovf_d;
`endif

  logic [WIDTH:0]       step_a;
  logic [WIDTH-1:0]     step_q;
  logic                 step_q_m1;
  logic [2*WIDTH-1:0]   step_product;

  booth_step #(.WIDTH(WIDTH)) u_step (
    .a_i    (a_q),
    .q_i    (q_q),
    .q_m1_i (q_m1_q),
    .m_i    (m_q),
    .a_o    (step_a),
    .q_o    (step_q),
    .q_m1_o (step_q_m1)
  );

  // The guard bit of A is dropped: after WIDTH steps the true product always
  // fits in {A[WIDTH-1:0], Q}, including (-2^(WIDTH-1))^2.
  assign step_product = {step_a[WIDTH-1:0], step_q};

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    a_d       = a_q;
    q_d       = q_q;
    q_m1_d    = q_m1_q;
    m_d       = m_q;
    product_d = product_q;
`ifdef BOOTH_OVF_EN
    ovf_d     = ovf_q;
`endif

    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = '0;
          q_d     = multiplier;
          q_m1_d  = 1'b0;
          m_d     = {multiplicand[WIDTH-1], multiplicand};
          count_d = CNT_W'(WIDTH);
          state_d = CALC;
        end
      end

      CALC: begin
        a_d     = step_a;
        q_d     = step_q;
        q_m1_d  = step_q_m1;
        count_d = count_q - 1'b1;
        // The step that brings count to zero is the last one; its result is
        // captured straight into the output register on the same edge.
        if (count_q == CNT_W'(1)) begin
          state_d   = DONE;
          product_d = step_product;
`ifdef BOOTH_OVF_EN
          ovf_d     = sign_bits_differ(64'(step_product[2*WIDTH-1:WIDTH-1]),
                                       unsigned'(WIDTH + 1));
`endif
        end
      end

      DONE: begin
        if (out_ready) state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order. All datapath
  // registers are reset too, so a mid-operation reset leaves nothing stale.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      count_q   <= '0;
      a_q       <= '0;
      q_q       <= '0;
      q_m1_q    <= 1'b0;
      m_q       <= '0;
      product_q <= '0;
`ifdef BOOTH_OVF_EN
      ovf_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      a_q       <= a_d;
      q_q       <= q_d;
      q_m1_q    <= q_m1_d;
      m_q       <= m_d;
      product_q <= product_d;
`ifdef BOOTH_OVF_EN
      ovf_q     <= ovf_d;
`endif
    end
  end

  // Handshake flags decode directly from the state register, so they are
  // glitch-free and change only on clock edges.
  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign product   = product_q;
`ifdef BOOTH_OVF_EN
  assign ovf       = ovf_q;
`endif

endmodule : booth_mult_seq

// File: tb/tb_booth_mult_seq.sv
// -----------------------------------------------------------------------------
// tb_booth_mult_seq
//   Self-checking bench for booth_mult_seq at WIDTH=32. Expected products come
//   from plain 64-bit signed multiplication; overflow from a range test.
//   Build with +define+BOOTH_OVF_EN to also check the ovf output.
// -----------------------------------------------------------------------------
module tb_booth_mult_seq;

  localparam int W = 32;

  logic           clk;
  logic           rst_n;
  logic           in_valid;
  logic           in_ready;
  logic [W-1:0]   multiplicand;
  logic [W-1:0]   multiplier;
  logic           out_valid;
  logic           out_ready;
  logic           ovf;
  logic [2*W-1:0] product;

  int n_checks = 0;
  int n_fail   = 0;

  booth_mult_seq #(.WIDTH(W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .multiplicand (multiplicand),
    .multiplier   (multiplier),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
`ifdef BOOTH_OVF_EN
    .ovf          (ovf),
`endif
    .product      (product)
  );

`ifndef BOOTH_OVF_EN
  assign ovf = 1'b0;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: full-precision signed product.
  function automatic logic [63:0] ref_prod(input logic [W-1:0] a, input logic [W-1:0] b);
    longint pa, pb;
    pa = longint'($signed(a));
    pb = longint'($signed(b));
    return 64'(pa * pb);
  endfunction

  // Reference overflow: product outside the W-bit signed range.
  function automatic logic ref_ovf(input logic [W-1:0] a, input logic [W-1:0] b);
    longint p;
    p = longint'($signed(a)) * longint'($signed(b));
`ifdef BOOTH_OVF_EN
    return (p > 64'sh7FFF_FFFF) || (p < -64'sh8000_0000);
`else
    return (p != p); // no ovf port: always 0
`endif
  endfunction

  // Drives one full operation and reports what was observed. Called with time
  // just after a rising edge and the DUT idle.
  task automatic do_mult(input logic [W-1:0] a, input logic [W-1:0] b, input int hold,
                         output logic [63:0] p, output logic ov, output int lat,
                         output logic rdy_busy, output logic rdy_after, output logic vld_after);
    multiplicand = a;
    multiplier   = b;
    in_valid     = 1'b1;
    @(posedge clk); #1;            // accepting edge = edge 1
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    p        = product;
    ov       = ovf;
    rdy_busy = in_ready;
    repeat (hold) begin @(posedge clk); #1; end
    out_ready = 1'b1;
    @(posedge clk); #1;            // output handshake edge
    out_ready = 1'b0;
    rdy_after = in_ready;
    vld_after = out_valid;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    multiplicand = '0; multiplier = '0;
    #12;
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    n_checks++; if (product !== 64'h0) begin n_fail++; $display("FAIL reset_product got=%h exp=0", product); end
    n_checks++; if (ovf !== 1'b0) begin n_fail++; $display("FAIL reset_ovf got=%b exp=0", ovf); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_directed();
    logic [W-1:0]  ta [4] = '{32'd7, 32'h8000_0000, 32'h0001_0000, 32'd0};
    logic [W-1:0]  tb [4] = '{32'hFFFF_FFFD, 32'h8000_0000, 32'h0001_0000, 32'h1234_5678};
    logic [63:0]   tp [4] = '{64'hFFFF_FFFF_FFFF_FFEB, 64'h4000_0000_0000_0000,
                              64'h0000_0001_0000_0000, 64'h0};
    logic          to [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
    logic [63:0] p; logic ov, rb, ra, va; int lat;
    for (int i = 0; i < 4; i++) begin
      do_mult(ta[i], tb[i], i, p, ov, lat, rb, ra, va);
      n_checks++; if (p !== tp[i]) begin n_fail++; $display("FAIL dir%0d_product got=%h exp=%h", i, p, tp[i]); end
      n_checks++; if (lat !== 33) begin n_fail++; $display("FAIL dir%0d_latency got=%0d exp=33", i, lat); end
`ifdef BOOTH_OVF_EN
      n_checks++; if (ov !== to[i]) begin n_fail++; $display("FAIL dir%0d_ovf got=%b exp=%b", i, ov, to[i]); end
`else
      n_checks++; if (ov !== 1'b0 || to[i] === 1'bx) begin n_fail++; $display("FAIL dir%0d_ovf got=%b exp=0", i, ov); end
`endif
      n_checks++; if (rb !== 1'b0) begin n_fail++; $display("FAIL dir%0d_busy_ready got=%b exp=0", i, rb); end
      n_checks++; if (ra !== 1'b1 || va !== 1'b0) begin n_fail++; $display("FAIL dir%0d_after_hs ready=%b valid=%b exp=1/0", i, ra, va); end
    end
  endtask

  task automatic test_backpressure();
    logic [63:0] exp_p; int lat; logic [63:0] p; logic ov, rb, ra, va;
    exp_p = ref_prod(32'hFFFF_1234, 32'h0000_ABCD);
    multiplicand = 32'hFFFF_1234; multiplier = 32'h0000_ABCD; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 200) begin @(posedge clk); #1; lat++; end
    n_checks++; if (lat !== 33) begin n_fail++; $display("FAIL bp_latency got=%0d exp=33", lat); end
    for (int i = 0; i < 10; i++) begin
      in_valid     = i[0];
      multiplicand = $urandom();
      multiplier   = $urandom();
      @(posedge clk); #1;
      n_checks++;
      if (product !== exp_p || out_valid !== 1'b1 || in_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL bp_hold%0d product=%h valid=%b ready=%b exp=%h/1/0", i, product, out_valid, in_ready, exp_p);
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    n_checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_release ready=%b valid=%b exp=1/0", in_ready, out_valid); end
    n_checks++; if (product !== exp_p) begin n_fail++; $display("FAIL bp_product_kept got=%h exp=%h", product, exp_p); end
    // Ignored pulses must not have started anything: the next op is clean.
    do_mult(32'd123, 32'hFFFF_FF00, 0, p, ov, lat, rb, ra, va);
    n_checks++; if (p !== ref_prod(32'd123, 32'hFFFF_FF00) || lat !== 33) begin n_fail++; $display("FAIL bp_next got=%h lat=%0d exp=%h lat=33", p, lat, ref_prod(32'd123, 32'hFFFF_FF00)); end
  endtask

  task automatic test_reset_abort();
    logic [63:0] p; logic ov, rb, ra, va; int lat;
    multiplicand = 32'd5; multiplier = 32'd5; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (15) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || product !== 64'h0 || ovf !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_reset ready=%b valid=%b product=%h ovf=%b exp=1/0/0/0", in_ready, out_valid, product, ovf);
    end
    @(posedge clk); #1;
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL abort_no_emit got=%b exp=0", out_valid); end
    rst_n = 1'b1;
    @(posedge clk); #1;
    do_mult(32'd2, 32'hFFFF_FFFE, 0, p, ov, lat, rb, ra, va);
    n_checks++; if (p !== 64'hFFFF_FFFF_FFFF_FFFC) begin n_fail++; $display("FAIL abort_next got=%h exp=fffffffffffffffc", p); end
    n_checks++; if (lat !== 33) begin n_fail++; $display("FAIL abort_next_latency got=%0d exp=33", lat); end
  endtask

  task automatic test_random();
    logic [W-1:0] corner [5] = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF};
    logic [W-1:0] a, b; logic [63:0] p; logic ov, rb, ra, va; int lat;
    for (int i = 0; i < 1500; i++) begin
      a = ($urandom_range(0, 7) == 0) ? corner[$urandom_range(0, 4)] : W'($urandom());
      b = ($urandom_range(0, 7) == 0) ? corner[$urandom_range(0, 4)] : W'($urandom());
      do_mult(a, b, $urandom_range(0, 2), p, ov, lat, rb, ra, va);
      n_checks++; if (p !== ref_prod(a, b)) begin n_fail++; $display("FAIL rnd%0d_product a=%h b=%h got=%h exp=%h", i, a, b, p, ref_prod(a, b)); end
      n_checks++; if (ov !== ref_ovf(a, b)) begin n_fail++; $display("FAIL rnd%0d_ovf got=%b exp=%b", i, ov, ref_ovf(a, b)); end
      n_checks++; if (lat !== 33) begin n_fail++; $display("FAIL rnd%0d_latency got=%0d exp=33", i, lat); end
      n_checks++; if (rb !== 1'b0 || ra !== 1'b1 || va !== 1'b0) begin n_fail++; $display("FAIL rnd%0d_handshake busy=%b after=%b valid=%b exp=0/1/0", i, rb, ra, va); end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_reset_abort();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_booth_mult_seq
